// File: rtl/dpr16x4_fifo_if.sv
// Producer/consumer side of the 16x4 FIFO controller.
// The FIFO is the slave. The bench or the surrounding logic is the master.
interface dpr16x4_fifo_if;
  logic       PUSH;
  logic [3:0] DIN;
  logic       POP;
  logic       CLR_ERR;
  logic [3:0] DOUT;
  logic       DVALID;
  logic       FULL;
  logic       EMPTY;
  logic       AFULL;
  logic       AEMPTY;
  logic [4:0] COUNT;
  logic       OVF;
  logic       UDF;

  modport master (
    output PUSH, DIN, POP, CLR_ERR,
    input  DOUT, DVALID, FULL, EMPTY, AFULL, AEMPTY, COUNT, OVF, UDF
  );

  modport slave (
    input  PUSH, DIN, POP, CLR_ERR,
    output DOUT, DVALID, FULL, EMPTY, AFULL, AEMPTY, COUNT, OVF, UDF
  );
endinterface

// File: rtl/dpr16x4_fifo_ctl.sv
// 16-deep x 4-bit FIFO controller that drives an external 16x4 dual-port RAM.
// It owns the pointers, occupancy, flags, sticky errors and the registered read data.
module dpr16x4_fifo_ctl #(
  parameter int         AFULL_TH  = 12,
  parameter int         AEMPTY_TH = 2,
  parameter logic [3:0] DOUT_RST  = 4'h0
) (
  input  logic              WCK,
  input  logic              RSTN,
  dpr16x4_fifo_if.slave     bus,
  output logic [3:0]        RAM_WAD,
  output logic [3:0]        RAM_DI,
  output logic              RAM_WRE,
  output logic [3:0]        RAM_RAD,
  input  logic [3:0]        RAM_DO
);

  localparam logic [4:0] AFULL_C  = 5'(AFULL_TH);
  localparam logic [4:0] AEMPTY_C = 5'(AEMPTY_TH);

  logic [4:0] wptr_q, wptr_d;
  logic [4:0] rptr_q, rptr_d;
  logic [4:0] count_q, count_d;
  logic [3:0] dout_q, dout_d;
  logic       dvalid_q, dvalid_d;
  logic       ovf_q, ovf_d;
  logic       udf_q, udf_d;
  logic       full_c, empty_c, wr_acc, rd_acc;

  // Acceptance uses only the flags registered at the start of the cycle.
  always_comb begin
    full_c   = (count_q == 5'd16);
    empty_c  = (count_q == 5'd0);
    wr_acc   = bus.PUSH & ~full_c;
    rd_acc   = bus.POP & ~empty_c;
    wptr_d   = wptr_q + {4'b0, wr_acc};
    rptr_d   = rptr_q + {4'b0, rd_acc};
    count_d  = count_q;
    if (wr_acc && !rd_acc) begin
      count_d = count_q + 5'd1;
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - 5'd1;
    end
    dout_d   = rd_acc ? RAM_DO : dout_q;
    dvalid_d = rd_acc;
    ovf_d    = (ovf_q & ~bus.CLR_ERR) | (bus.PUSH & full_c);
    udf_d    = (udf_q & ~bus.CLR_ERR) | (bus.POP & empty_c);
  end

  always_ff @(posedge WCK or negedge RSTN) begin
    if (!RSTN) begin
      wptr_q   <= 5'd0;
      rptr_q   <= 5'd0;
      count_q  <= 5'd0;
      dout_q   <= DOUT_RST;
      dvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // The RAM commits on WCK, so the write strobe is gated while reset is held.
  assign RAM_WAD    = wptr_q[3:0];
  assign RAM_DI     = bus.DIN;
  assign RAM_WRE    = wr_acc & RSTN;
  assign RAM_RAD    = rptr_q[3:0];

  assign bus.DOUT   = dout_q;
  assign bus.DVALID = dvalid_q;
  assign bus.FULL   = full_c;
  assign bus.EMPTY  = empty_c;
  assign bus.AFULL  = (count_q >= AFULL_C);
  assign bus.AEMPTY = (count_q <= AEMPTY_C);
  assign bus.COUNT  = count_q;
  assign bus.OVF    = ovf_q;
  assign bus.UDF    = udf_q;

  // The registered count must agree with the wrap-bit pointer relation.
  a_full_ptr : assert property (@(posedge WCK) disable iff (!RSTN)
    full_c == ((wptr_q[3:0] == rptr_q[3:0]) && (wptr_q[4] != rptr_q[4])));
  a_empty_ptr : assert property (@(posedge WCK) disable iff (!RSTN)
    empty_c == (wptr_q == rptr_q));

endmodule
